// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// reqstate_t is the state encoding of the request unit FSM.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/req_perf_counter.sv
// Stall-cycle and retired-instruction counters for the request unit.
// Both counters wrap at 2^32 and clear on synchronous active-low reset.
module req_perf_counter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  input  logic        retire,
  output logic [31:0] stall_cycles,
  output logic [31:0] instr_count
);

  logic [31:0] stall_q;
  logic [31:0] instr_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      if (stall) begin
        stall_q <= stall_q + 32'd1;
      end
      if (retire) begin
        instr_q <= instr_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign instr_count  = instr_q;

endmodule

// File: rtl/request_unit.sv
// Sequences instruction fetch and data access requests to memory, and halts the core.
// Define REQ_PERF_EN to build the stall/retire performance counters.
module request_unit
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iread,
  input  logic        dread,
  input  logic        dwrite,
  input  logic        halt,
  input  logic        ihit,
  input  logic        dhit,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] instr_count
);

  reqstate_t state_q, state_d;
  logic      rd_q, rd_d;
  logic      wr_q, wr_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pc_en   = 1'b0;
    unique case (state_q)
      FETCH: begin
        imemREN = iread;
        if (ihit) begin
          if (halt) begin
            state_d = HALTED;
          end else if (dread || dwrite) begin
            // A simultaneous read and write request is treated as a store.
            state_d = DATA;
            wr_d    = dwrite;
            rd_d    = dread & ~dwrite;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        dmemREN = rd_q;
        dmemWEN = wr_q;
        if (dhit) begin
          state_d = FETCH;
          pc_en   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign halted = (state_q == HALTED);

`ifdef REQ_PERF_EN
  logic stall;

  // A stall is a cycle with an outstanding enable that is not answered by its hit strobe.
  assign stall = ((state_q == FETCH) && imemREN && !ihit) ||
                 ((state_q == DATA) && (dmemREN || dmemWEN) && !dhit);

  req_perf_counter u_perf (
    .CLK          (CLK),
    .nRST         (nRST),
    .stall        (stall),
    .retire       (pc_en),
    .stall_cycles (stall_cycles),
    .instr_count  (instr_count)
  );
`else
  assign stall_cycles = 32'd0;
  assign instr_count  = 32'd0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_request_unit;

  logic        clk;
  logic        nrst;
  logic        iread, dread, dwrite, halt, ihit, dhit;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halted;
  logic [31:0] stall_cycles, instr_count;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Expected output order: {imemREN, dmemREN, dmemWEN, pc_en, halted}
  logic [4:0] exp_q[$];
  string      name_q[$];

  request_unit dut (
    .CLK          (clk),
    .nRST         (nrst),
    .iread        (iread),
    .dread        (dread),
    .dwrite       (dwrite),
    .halt         (halt),
    .ihit         (ihit),
    .dhit         (dhit),
    .imemREN      (imemREN),
    .dmemREN      (dmemREN),
    .dmemWEN      (dmemWEN),
    .pc_en        (pc_en),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every cycle carries an output, so one expectation is consumed per negedge.
  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] act_v;
    string      nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {imemREN, dmemREN, dmemWEN, pc_en, halted};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: outputs {imem,dren,dwen,pc_en,halted} got %b expected %b",
                 nm, act_v, exp_v);
      end
    end
    if (checking) begin
      checks++;
      if ($countones({imemREN, dmemREN, dmemWEN}) > 1) begin
        errors++;
        $display("FAIL one_enable: enables got %b expected at most one set",
                 {imemREN, dmemREN, dmemWEN});
      end
    end
  end

  // in order: {iread, dread, dwrite, halt, ihit, dhit}
  task automatic step(input logic n, input logic [5:0] in_v, input logic [4:0] exp_v,
                      input string nm);
    @(posedge clk);
    #1;
    nrst = n;
    {iread, dread, dwrite, halt, ihit, dhit} = in_v;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  initial begin
    nrst = 1'b0;
    {iread, dread, dwrite, halt, ihit, dhit} = 6'b000000;
    repeat (2) @(posedge clk);

    step(1'b0, 6'b000000, 5'b00000, "rst_state");
    checking = 1'b1;

    // Fetch-only: ihit on third request cycle
    step(1'b1, 6'b100000, 5'b10000, "fetch_c1");
    step(1'b1, 6'b100000, 5'b10000, "fetch_c2");
    step(1'b1, 6'b100010, 5'b10010, "fetch_hit");
    step(1'b1, 6'b100000, 5'b10000, "fetch_next");

    // Load, dhit two cycles into DATA; ihit in DATA and dropped dread are ignored
    step(1'b1, 6'b110010, 5'b10000, "ld_ihit");
    step(1'b1, 6'b100010, 5'b01000, "ld_wait");
    step(1'b1, 6'b100001, 5'b01010, "ld_dhit");
    step(1'b1, 6'b100000, 5'b10000, "ld_back");

    // Read+write at latch time becomes a store; dhit in FETCH ignored
    step(1'b1, 6'b111010, 5'b10000, "st_ihit");
    step(1'b1, 6'b110000, 5'b00100, "st_wait");
    step(1'b1, 6'b000001, 5'b00110, "st_dhit");
    step(1'b1, 6'b000001, 5'b00000, "dhit_fetch_ign");
    step(1'b1, 6'b100000, 5'b10000, "fetch_after_ign");

    // Reset while in DATA
    step(1'b1, 6'b101010, 5'b10000, "st2_ihit");
    step(1'b0, 6'b000000, 5'b00100, "rst_in_data");
    step(1'b1, 6'b100000, 5'b10000, "post_rst_data");

    // Halt wins over a store; HALTED absorbs hit toggling
    step(1'b1, 6'b101110, 5'b10000, "halt_ihit");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 2 == 1) ? 6'b110010 : 6'b101001, 5'b00001, "halted_hold");
    end
    step(1'b0, 6'b100010, 5'b00001, "rst_in_halted");
    step(1'b1, 6'b100000, 5'b10000, "post_rst_halt");

    // Counter workload: 3 fetch-only + 1 load with 4 wait cycles
    step(1'b0, 6'b000000, 5'b00000, "rst_pre_perf");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'b100010, 5'b10010, "perf_fetch");
    end
    step(1'b1, 6'b110010, 5'b10000, "perf_ld_ihit");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 6'b000000, 5'b01000, "perf_ld_wait");
    end
    step(1'b1, 6'b000001, 5'b01010, "perf_ld_dhit");
    step(1'b1, 6'b000000, 5'b00000, "perf_idle");
    @(posedge clk);
    #1;

`ifdef REQ_PERF_EN
    checks++;
    if (instr_count !== 32'd4) begin
      errors++;
      $display("FAIL instr_count: got %0d expected 4", instr_count);
    end
    checks++;
    if (stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 4", stall_cycles);
    end
`else
    checks++;
    if (instr_count !== 32'd0) begin
      errors++;
      $display("FAIL instr_count_tied: got %0d expected 0", instr_count);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL stall_cycles_tied: got %0d expected 0", stall_cycles);
    end
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL: CLK  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL: nRST  in  1  reset, synchronous, active-low.
REQ-003 SHALL: iread  in  1  instruction fetch request from control unit.
REQ-004 SHALL: dread  in  1  data load request from control unit.
REQ-005 SHALL: dwrite  in  1  data store request from control unit.
REQ-006 SHALL: halt  in  1  halt decoded by control unit.
REQ-007 SHALL: ihit  in  1  instruction memory/cache completion strobe.
REQ-008 SHALL: dhit  in  1  data memory/cache completion strobe.
REQ-009 SHALL: imemREN  out  1  instruction read enable to memory.
REQ-010 SHALL: dmemREN  out  1  data read enable to memory.
REQ-011 SHALL: dmemWEN  out  1  data write enable to memory.
REQ-012 SHALL: pc_en  out  1  one-cycle pulse allowing PC/register-file commit.
REQ-013 SHALL: halted  out  1  processor halted flag.
REQ-014 SHALL: stall_cycles  out  32  cycles spent waiting on ihit/dhit (REQ_PERF_EN only).
REQ-015 SHALL: instr_count  out  32  retired instructions (REQ_PERF_EN only).

Function
REQ-016 SHALL: FSM states FETCH, DATA, HALTED; next state registered, outputs decoded from state plus latched requests.
REQ-017 SHALL: in FETCH, imemREN = iread; dmemREN = dmemWEN = 0.
REQ-018 SHALL: FETCH + ihit + halt -> HALTED, pc_en = 0, no data access issued even if dread/dwrite also high.
REQ-019 SHALL: FETCH + ihit + (dread|dwrite) + !halt -> DATA; latch dread/dwrite on that edge; pc_en = 0.
REQ-020 SHALL: FETCH + ihit with no data request and !halt -> stay FETCH, pc_en = 1 for exactly that cycle.
REQ-021 SHALL: in DATA, imemREN = 0, dmemREN/dmemWEN = latched values, held stable until dhit regardless of input changes.
REQ-022 SHALL: dread and dwrite both high at latch time -> latch write only (dmemWEN = 1, dmemREN = 0).
REQ-023 SHALL: DATA + dhit -> FETCH, pc_en = 1 that cycle, latched requests cleared on the same edge.
REQ-024 SHALL: dhit in FETCH and ihit in DATA ignored, no state change.
REQ-025 SHALL: HALTED absorbing until reset; imemREN, dmemREN, dmemWEN, pc_en = 0; halted = 1.
REQ-026 SHALL: at most one memory enable asserted in any cycle.
REQ-027 SHALL: fetch-only instruction latency = cycles to ihit; load/store latency = cycles to ihit + cycles to dhit + 0 added cycles.

Reset
REQ-028 SHALL: nRST low at a rising edge -> state FETCH, latched requests 0, halted 0, pc_en 0, counters 0, also mid-DATA or in HALTED.
REQ-029 SHALL: first cycle after reset release, imemREN = iread.

Configuration
REQ-030 SHALL: macro REQ_PERF_EN defined -> stall_cycles increments every non-HALTED cycle whose enabled request sees no hit; instr_count increments on each pc_en; both wrap at 2^32.
REQ-031 SHALL: REQ_PERF_EN undefined -> stall_cycles and instr_count ports tied to 0, no counter flops.

Structure
REQ-032 SHALL: enum reqstate_t {FETCH, DATA, HALTED} placed in cpu_types_pkg; no other new package constants.
REQ-033 SHALL: counters in sub-module req_perf_counter, instantiated only under REQ_PERF_EN.

Verification
REQ-034 SHALL: reset, iread=1, ihit on cycle 3, no data req -> imemREN high cycles 1-3, pc_en pulse cycle 3, state FETCH.
REQ-035 SHALL: ihit with dread=1, dhit 2 cycles later -> dmemREN high 2 cycles, pc_en only on dhit cycle, imemREN 0 during DATA.
REQ-036 SHALL: ihit with dread=dwrite=1 -> dmemWEN=1, dmemREN=0 until dhit.
REQ-037 SHALL: ihit with halt=1, dwrite=1 -> HALTED next cycle, halted=1, all enables 0 for 10 further cycles despite ihit/dhit toggling.
REQ-038 SHALL: nRST low while in DATA -> next cycle FETCH, dmemWEN 0, halted 0; REQ_PERF_EN build: 3 fetch-only + 1 load with 4 wait cycles -> instr_count=4, stall_cycles=4 (hits on first request cycle).
